// File: rtl/imem_read_responder_if.sv
// Fetch read port (S_R_*) and line-fill port (M_R_*) bundle for imem_read_responder.
// slave is the responder's view; master is the fetch stage / memory view.
interface imem_read_responder_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] S_R_ADDR;
  logic                  S_R_ADDR_VALID;
  logic [31:0]           S_R_DATA;
  logic                  S_R_DATA_VALID;

  logic [ADDR_WIDTH-1:0] M_R_ADDR;
  logic                  M_R_ADDR_VALID;
  logic                  M_R_ADDR_READY;
  logic [DATA_WIDTH-1:0] M_R_DATA;
  logic                  M_R_DATA_VALID;

  modport slave (
    input  S_R_ADDR, S_R_ADDR_VALID, M_R_ADDR_READY, M_R_DATA, M_R_DATA_VALID,
    output S_R_DATA, S_R_DATA_VALID, M_R_ADDR, M_R_ADDR_VALID
  );

  modport master (
    output S_R_ADDR, S_R_ADDR_VALID, M_R_ADDR_READY, M_R_DATA, M_R_DATA_VALID,
    input  S_R_DATA, S_R_DATA_VALID, M_R_ADDR, M_R_ADDR_VALID
  );
endinterface

// File: rtl/imem_read_responder.sv
// Instruction-fetch read responder backed by a single line buffer refilled over M_R_*.
// Define IMEM_LINE_BUFFER_EN to serve hits from the line buffer; otherwise every request refills.
module imem_read_responder #(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int BUFFER_SIZE = 512
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  imem_read_responder_if.slave bus
);
  localparam int BEATS       = BUFFER_SIZE / DATA_WIDTH;
  localparam int WORDS       = BUFFER_SIZE / 32;
  localparam int LINE_BYTES  = BUFFER_SIZE / 8;
  localparam int OFFSET_BITS = $clog2(LINE_BYTES);
  localparam int BEAT_BITS   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WORD_BITS   = $clog2(WORDS);
  localparam int TAG_BITS    = ADDR_WIDTH - OFFSET_BITS;

  typedef enum logic [1:0] {IDLE, REQ, FILL, RESP} state_t;

  state_t                           state, state_next;
  logic [ADDR_WIDTH-1:2]            req_addr;
  logic [BEAT_BITS-1:0]             beat_cnt;
  logic                             line_valid;
  logic                             flush_seen;
  logic [TAG_BITS-1:0]              line_tag;
  logic [BEATS-1:0][DATA_WIDTH-1:0] line;
  logic [WORDS-1:0][31:0]           line_words;
  logic [WORD_BITS-1:0]             word_idx;
  logic [TAG_BITS-1:0]              in_tag;

  logic [31:0]                      resp_data;
  logic                             resp_valid;
  logic [ADDR_WIDTH-1:0]            fill_addr;
  logic                             fill_addr_valid;

  logic sample, hit, handshake, fill_beat, fill_done;

  // Fetch address bits [1:0] are word-aligned by contract and never looked at.
  wire unused_addr_bits = &{1'b0, bus.S_R_ADDR[1:0]};

  assign in_tag     = bus.S_R_ADDR[ADDR_WIDTH-1:OFFSET_BITS];
  assign word_idx   = req_addr[OFFSET_BITS-1:2];
  assign line_words = line;

  assign sample    = (state == IDLE) && bus.S_R_ADDR_VALID;
  assign handshake = (state == REQ) && bus.M_R_ADDR_READY;
  assign fill_beat = (state == FILL) && bus.M_R_DATA_VALID;
  assign fill_done = fill_beat && (beat_cnt == BEAT_BITS'(BEATS - 1));

`ifdef IMEM_LINE_BUFFER_EN
  assign hit = line_valid && (in_tag == line_tag);
`else
  // Buffer bookkeeping is kept so both builds share one datapath; it just never hits.
  assign hit = 1'b0;
  wire unused_line_state = ^{1'b0, line_valid, line_tag};
`endif

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.S_R_ADDR_VALID) state_next = hit ? RESP : REQ;
      REQ:     if (bus.M_R_ADDR_READY) state_next = FILL;
      FILL:    if (fill_done)          state_next = RESP;
      RESP:                            state_next = IDLE;
      default:                         state_next = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      req_addr        <= '0;
      beat_cnt        <= '0;
      line_valid      <= 1'b0;
      flush_seen      <= 1'b0;
      resp_data       <= '0;
      resp_valid      <= 1'b0;
      fill_addr       <= '0;
      fill_addr_valid <= 1'b0;
    end else begin
      state <= state_next;

      if (sample) req_addr <= bus.S_R_ADDR[ADDR_WIDTH-1:2];

      if (sample && !hit) begin
        fill_addr       <= {in_tag, {OFFSET_BITS{1'b0}}};
        fill_addr_valid <= 1'b1;
      end else if (handshake) begin
        fill_addr_valid <= 1'b0;
      end

      if (handshake)      beat_cnt <= '0;
      else if (fill_beat) beat_cnt <= beat_cnt + 1'b1;

      // A flush seen while the line is in flight keeps the finished line invalid.
      if (sample)     flush_seen <= 1'b0;
      else if (flush) flush_seen <= 1'b1;

      if (flush)          line_valid <= 1'b0;
      else if (fill_done) line_valid <= !flush_seen;

      resp_valid <= (state == RESP);
      resp_data  <= (state == RESP) ? line_words[word_idx] : 32'h0;
    end
  end

  // NOTE: the line buffer and tag are pure storage qualified by line_valid, so
  // they carry no reset.
  always_ff @(posedge clk) begin
    if (fill_beat) line[beat_cnt] <= bus.M_R_DATA;
    if (fill_done) line_tag       <= req_addr[ADDR_WIDTH-1:OFFSET_BITS];
  end

  assign bus.S_R_DATA       = resp_data;
  assign bus.S_R_DATA_VALID = resp_valid;
  assign bus.M_R_ADDR       = fill_addr;
  assign bus.M_R_ADDR_VALID = fill_addr_valid;
endmodule

// File: tb/tb_imem_read_responder.sv
// Directed bench for imem_read_responder; expectations follow IMEM_LINE_BUFFER_EN when defined.
// Fill f, word w of a line carries {f, 24'(0xA + w)}.
module tb_imem_read_responder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   failures = 0;

  imem_read_responder_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();

  imem_read_responder dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef IMEM_LINE_BUFFER_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  function automatic logic [63:0] beat_value(input logic [7:0] f, input int k);
    logic [31:0] lo;
    logic [31:0] hi;
    lo = {f, 24'h0} | 32'(10 + 2 * k);
    hi = {f, 24'h0} | 32'(11 + 2 * k);
    return {hi, lo};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and plays memory; reports what the DUT did. Starts and ends at a sample point.
  task automatic do_request(
    input  logic [63:0] addr,
    input  int          ready_delay,
    input  int          flush_beat,
    input  logic [7:0]  fill_id,
    output logic [31:0] data,
    output int          latency,
    output int          fills,
    output int          valid_cycles,
    output logic [63:0] maddr,
    output bit          addr_stable,
    output bit          pulse_ok,
    output bit          timeout
  );
    int  beat;
    bit  in_fill;
    data = '0; latency = 0; fills = 0; valid_cycles = 0; maddr = '0;
    addr_stable = 1'b1; pulse_ok = 1'b1; timeout = 1'b1;
    beat = 0; in_fill = 1'b0;
    bus.S_R_ADDR = addr;
    bus.S_R_ADDR_VALID = 1'b1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      step();
      if (cyc == 1) begin
        bus.S_R_ADDR_VALID = 1'b0;
        bus.S_R_ADDR = 64'hDEAD_BEEF_0000_0000;
      end
      bus.M_R_ADDR_READY = 1'b0;
      bus.M_R_DATA_VALID = 1'b0;
      flush = 1'b0;
      if (bus.S_R_DATA_VALID) begin
        data = bus.S_R_DATA;
        latency = cyc;
        timeout = 1'b0;
        step();
        if (bus.S_R_DATA_VALID !== 1'b0 || bus.S_R_DATA !== 32'h0) pulse_ok = 1'b0;
        break;
      end
      if (bus.S_R_DATA !== 32'h0) pulse_ok = 1'b0;
      if (bus.M_R_ADDR_VALID && !in_fill) begin
        if (valid_cycles == 0) begin
          maddr = bus.M_R_ADDR;
          fills++;
        end else if (bus.M_R_ADDR !== maddr) begin
          addr_stable = 1'b0;
        end
        valid_cycles++;
        if (valid_cycles > ready_delay) begin
          bus.M_R_ADDR_READY = 1'b1;
          in_fill = 1'b1;
        end
      end else if (in_fill && beat < 8) begin
        bus.M_R_DATA = beat_value(fill_id, beat);
        bus.M_R_DATA_VALID = 1'b1;
        if (beat == flush_beat) flush = 1'b1;
        beat++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.S_R_ADDR = '0; bus.S_R_ADDR_VALID = 1'b0;
    bus.M_R_ADDR_READY = 1'b0; bus.M_R_DATA = '0; bus.M_R_DATA_VALID = 1'b0;
    repeat (2) step();
    checks++;
    if ({bus.S_R_DATA_VALID, bus.M_R_ADDR_VALID} !== 2'b00) begin
      failures++;
      $display("FAIL reset_valids: got %b expected 00", {bus.S_R_DATA_VALID, bus.M_R_ADDR_VALID});
    end
    checks++;
    if (bus.S_R_DATA !== 32'h0 || bus.M_R_ADDR !== 64'h0) begin
      failures++;
      $display("FAIL reset_data: got S_R_DATA=%h M_R_ADDR=%h expected 0", bus.S_R_DATA, bus.M_R_ADDR);
    end
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({bus.S_R_DATA_VALID, bus.M_R_ADDR_VALID} !== 2'b00) begin
      failures++;
      $display("FAIL idle_after_reset: got %b expected 00", {bus.S_R_DATA_VALID, bus.M_R_ADDR_VALID});
    end
  endtask

  task automatic test_miss_basic();
    logic [31:0] d; logic [63:0] ma; int lat, nf, vc; bit st, po, to;
    do_request(64'h1000, 0, -1, 8'h00, d, lat, nf, vc, ma, st, po, to);
    checks++;
    if (to) begin failures++; $display("FAIL miss_timeout: got no response expected pulse"); end
    checks++;
    if (nf !== 1 || ma !== 64'h1000) begin
      failures++; $display("FAIL miss_fill_addr: got fills=%0d addr=%h expected 1 / 1000", nf, ma);
    end
    checks++;
    if (d !== 32'h0000000A) begin failures++; $display("FAIL miss_data: got %h expected 0000000a", d); end
    checks++;
    if (lat !== 11) begin failures++; $display("FAIL miss_latency: got %0d expected 11", lat); end
    checks++;
    if (!po) begin failures++; $display("FAIL miss_pulse: got wide pulse or stray data expected one-cycle pulse"); end
  endtask

  task automatic test_hits();
    logic [31:0] d; logic [63:0] ma; int lat, nf, vc; bit st, po, to;
    do_request(64'h1004, 0, -1, 8'h01, d, lat, nf, vc, ma, st, po, to);
    checks++;
    if (d !== (BUF_EN ? 32'h0000000B : 32'h0100000B)) begin
      failures++; $display("FAIL hit1_data: got %h expected %h", d, BUF_EN ? 32'h0000000B : 32'h0100000B);
    end
    checks++;
    if (nf !== (BUF_EN ? 0 : 1) || lat !== (BUF_EN ? 2 : 11)) begin
      failures++; $display("FAIL hit1_path: got fills=%0d latency=%0d", nf, lat);
    end
    checks++;
    if (!BUF_EN && ma !== 64'h1000) begin failures++; $display("FAIL hit1_refill_addr: got %h expected 1000", ma); end
    do_request(64'h103C, 0, -1, 8'h02, d, lat, nf, vc, ma, st, po, to);
    checks++;
    if (d !== (BUF_EN ? 32'h00000019 : 32'h02000019)) begin
      failures++; $display("FAIL hit2_data: got %h expected %h", d, BUF_EN ? 32'h00000019 : 32'h02000019);
    end
    checks++;
    if (nf !== (BUF_EN ? 0 : 1) || lat !== (BUF_EN ? 2 : 11) || !po) begin
      failures++; $display("FAIL hit2_path: got fills=%0d latency=%0d pulse_ok=%0d", nf, lat, po);
    end
  endtask

  task automatic test_ready_stall();
    logic [31:0] d; logic [63:0] ma; int lat, nf, vc; bit st, po, to;
    do_request(64'h2008, 5, -1, 8'h03, d, lat, nf, vc, ma, st, po, to);
    checks++;
    if (ma !== 64'h2000 || !st) begin
      failures++; $display("FAIL stall_addr: got %h stable=%0d expected 2000 stable", ma, st);
    end
    checks++;
    if (vc !== 6) begin failures++; $display("FAIL stall_valid_cycles: got %0d expected 6", vc); end
    checks++;
    if (d !== 32'h0300000C || lat !== 16) begin
      failures++; $display("FAIL stall_resp: got %h at %0d expected 0300000c at 16", d, lat);
    end
  endtask

  task automatic test_flush();
    logic [31:0] d; logic [63:0] ma; int lat, nf, vc; bit st, po, to;
    do_request(64'h3000, 0, 3, 8'h04, d, lat, nf, vc, ma, st, po, to);
    checks++;
    if (d !== 32'h0400000A || lat !== 11) begin
      failures++; $display("FAIL flush_inflight_resp: got %h at %0d expected 0400000a at 11", d, lat);
    end
    do_request(64'h3004, 0, -1, 8'h05, d, lat, nf, vc, ma, st, po, to);
    checks++;
    if (nf !== 1 || ma !== 64'h3000 || d !== 32'h0500000B) begin
      failures++; $display("FAIL flush_then_miss: got fills=%0d addr=%h data=%h expected 1/3000/0500000b", nf, ma, d);
    end
    do_request(64'h3008, 0, -1, 8'h06, d, lat, nf, vc, ma, st, po, to);
    checks++;
    if (d !== (BUF_EN ? 32'h0500000C : 32'h0600000C) || lat !== (BUF_EN ? 2 : 11)) begin
      failures++; $display("FAIL refilled_line: got %h at %0d", d, lat);
    end
    do_request(64'h5000, 0, 7, 8'h07, d, lat, nf, vc, ma, st, po, to);
    checks++;
    if (d !== 32'h0700000A) begin failures++; $display("FAIL flush_last_beat_resp: got %h expected 0700000a", d); end
    do_request(64'h5004, 0, -1, 8'h08, d, lat, nf, vc, ma, st, po, to);
    checks++;
    if (nf !== 1 || d !== 32'h0800000B) begin
      failures++; $display("FAIL flush_priority_miss: got fills=%0d data=%h expected 1/0800000b", nf, d);
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] d; logic [63:0] ma; int lat, nf, vc; bit st, po, to;
    bit seen; bit quiet;
    seen = 1'b0; quiet = 1'b1;
    bus.S_R_ADDR = 64'h4000;
    bus.S_R_ADDR_VALID = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      bus.S_R_ADDR_VALID = 1'b0;
      if (bus.M_R_ADDR_VALID) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || bus.M_R_ADDR !== 64'h4000) begin
      failures++; $display("FAIL midfill_req: got seen=%0d addr=%h expected 1/4000", seen, bus.M_R_ADDR);
    end
    bus.M_R_ADDR_READY = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      bus.M_R_ADDR_READY = 1'b0;
      bus.M_R_DATA = beat_value(8'h0C, k);
      bus.M_R_DATA_VALID = 1'b1;
    end
    step();
    bus.M_R_DATA = beat_value(8'h0C, 3);
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.S_R_DATA_VALID, bus.M_R_ADDR_VALID} !== 2'b00 || bus.S_R_DATA !== 32'h0 || bus.M_R_ADDR !== 64'h0) begin
      failures++; $display("FAIL midfill_reset_outputs: got M_R_ADDR=%h valids=%b expected all 0",
                           bus.M_R_ADDR, {bus.S_R_DATA_VALID, bus.M_R_ADDR_VALID});
    end
    repeat (2) step();
    reset = 1'b1;
    for (int k = 4; k < 9; k++) begin
      bus.M_R_DATA = beat_value(8'h0C, k);
      bus.M_R_DATA_VALID = 1'b1;
      step();
      if (bus.S_R_DATA_VALID || bus.M_R_ADDR_VALID) quiet = 1'b0;
    end
    bus.M_R_DATA_VALID = 1'b0;
    checks++;
    if (!quiet) begin failures++; $display("FAIL stray_beats: got activity expected outputs idle"); end
    do_request(64'h5008, 0, -1, 8'h0A, d, lat, nf, vc, ma, st, po, to);
    checks++;
    if (nf !== 1 || d !== 32'h0A00000C) begin
      failures++; $display("FAIL post_reset_line_invalid: got fills=%0d data=%h expected 1/0a00000c", nf, d);
    end
    do_request(64'h4000, 0, -1, 8'h0B, d, lat, nf, vc, ma, st, po, to);
    checks++;
    if (nf !== 1 || ma !== 64'h4000 || d !== 32'h0B00000A || lat !== 11 || !po) begin
      failures++; $display("FAIL post_reset_fill: got fills=%0d addr=%h data=%h latency=%0d expected 1/4000/0b00000a/11",
                           nf, ma, d, lat);
    end
  endtask

  initial begin
    test_reset();
    test_miss_basic();
    test_hits();
    test_ready_stall();
    test_flush();
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
